// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the RISC-V datapath: sequences estado, decodes control strobes, counts retired instructions.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap to HALT with a sticky illegal flag instead of acting as NOPs.
module unidade_controle_multiciclo #(
  parameter int PROG_LEN = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  output logic [3:0]       estado,
  output logic             ir_valid,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src_imm,
  output logic             alu_sub,
  output logic             wb_sel_mem,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    HALT   = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state, state_nxt;
  logic   retire;
  logic   taken;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic   illegal_set;
`endif

  assign estado = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)            illegal <= 1'b0;
    else if (illegal_set) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    ir_valid    = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_src_imm = 1'b0;
    alu_sub     = 1'b0;
    wb_sel_mem  = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    halted      = 1'b0;
    retire      = 1'b0;
    taken       = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    case (state)
      FETCH: state_nxt = (pc >= 32'(PROG_LEN)) ? HALT : DECODE;
      DECODE: begin
        ir_valid = 1'b1;
        case (opcode)
          OP_R:               state_nxt = EXEC_R;
          OP_I:               state_nxt = EXEC_I;
          OP_LOAD, OP_STORE:  state_nxt = ADDR;
          OP_BRANCH:          state_nxt = BRANCH;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_set = 1'b1;
            state_nxt   = HALT;
`else
            pc_inc    = 1'b1;
            retire    = 1'b1;
            state_nxt = FETCH;
`endif
          end
        endcase
      end
      EXEC_R: begin
        ir_valid  = 1'b1;
        state_nxt = WB_ALU;
      end
      EXEC_I: begin
        ir_valid    = 1'b1;
        alu_src_imm = 1'b1;
        state_nxt   = WB_ALU;
      end
      ADDR: begin
        ir_valid    = 1'b1;
        alu_src_imm = 1'b1;
        state_nxt   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        ir_valid  = 1'b1;
        mem_read  = 1'b1;
        state_nxt = WB_MEM;
      end
      MEM_WR: begin
        ir_valid  = 1'b1;
        mem_write = 1'b1;
        pc_inc    = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      WB_ALU: begin
        ir_valid  = 1'b1;
        reg_write = 1'b1;
        pc_inc    = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      WB_MEM: begin
        ir_valid   = 1'b1;
        reg_write  = 1'b1;
        wb_sel_mem = 1'b1;
        pc_inc     = 1'b1;
        retire     = 1'b1;
        state_nxt  = FETCH;
      end
      BRANCH: begin
        // beq/bne only; every other funct3 falls through as not taken
        taken     = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
        ir_valid  = 1'b1;
        alu_sub   = 1'b1;
        pc_branch = taken;
        pc_inc    = !taken;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      HALT: begin
        halted    = 1'b1;
        state_nxt = HALT;
      end
      default: state_nxt = HALT;
    endcase
  end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
Multicycle control FSM that sequences the RISC-V datapath. It drives the 4-bit `estado` bus consumed by the instruction-fetch block, which latches `instrucao` on the clock edge where `estado == 4'b0000`. From the fetched opcode/funct3 and the ALU zero flag it generates per-state control strobes. It also stops execution once PC runs past the program length.

Parameters:
PROG_LEN, 4, number of words in the instruction memory; fetch is allowed only while pc < PROG_LEN.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
pc  input  32  current PC as a word index (PC+1 = next instruction).
opcode  input  7  instrucao[6:0].
funct3  input  3  instrucao[14:12].
zero  input  1  ALU zero flag, valid in BRANCH.
estado  output  4  current FSM state, registered.
ir_valid  output  1  high in every state except FETCH and HALT; instrucao is stable.
reg_write  output  1  register-file write enable.
mem_read  output  1  data-memory read strobe.
mem_write  output  1  data-memory write strobe.
alu_src_imm  output  1  ALU operand B = immediate.
alu_sub  output  1  ALU subtract; used for branch compare.
wb_sel_mem  output  1  writeback source = memory data.
pc_inc  output  1  one-cycle pulse: pc <= pc + 1.
pc_branch  output  1  one-cycle pulse: pc <= pc + branch offset.
halted  output  1  FSM is in HALT.
illegal  output  1  sticky; unknown opcode seen (feature only, else tied 0).
instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, HALT=10. Values 11–15 go to HALT.
- Reset (synchronous):
  - estado=FETCH, instr_count=0, illegal=0.
  - All strobes are 0 in FETCH, so every output is 0 during and after reset.
- Strobes are combinational decodes of estado. pc_branch and pc_inc in BRANCH also depend on zero and funct3.
- FETCH: if pc >= PROG_LEN go to HALT; else go to DECODE. The fetch block latches instrucao on this edge.
- DECODE, by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 and 0100011 → ADDR
  - 1100011 → BRANCH
  - anything else: see Optional Feature.
- EXEC_R (alu_src_imm=0) → WB_ALU.
- EXEC_I (alu_src_imm=1) → WB_ALU.
- ADDR (alu_src_imm=1): → MEM_RD if opcode is load; → MEM_WR if opcode is store.
- MEM_RD: mem_read=1 → WB_MEM.
- MEM_WR: mem_write=1, pc_inc=1, retire → FETCH.
- WB_ALU: reg_write=1, pc_inc=1, retire → FETCH.
- WB_MEM: reg_write=1, wb_sel_mem=1, pc_inc=1, retire → FETCH.
- BRANCH: alu_sub=1.
  - Taken when (funct3=000 and zero=1) or (funct3=001 and zero=0). Taken → pc_branch=1; otherwise pc_inc=1.
  - Any other funct3 is not taken. Retire → FETCH.
  - pc_inc and pc_branch are never high together.
- HALT: absorbing state with halted=1; only reset leaves it.
- Latencies: R/I = 4 cycles, load = 5, store = 4, branch = 3 (FETCH to next FETCH).
- Retire means instr_count += 1 on the exit edge. The counter wraps at 2^CNT_W − 1 → 0.
- If reset and a retire coincide, reset wins: instr_count=0.

Optional Feature:
Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE sets illegal=1 (sticky until reset) and goes to HALT; no pc_inc, no retire.
- Undefined: an unknown opcode is treated as a NOP. DECODE pulses pc_inc, retires, and returns to FETCH. illegal is tied 0.

Test Plan:
- Reset held 2 cycles, then released → estado=0, all strobes 0, instr_count=0, halted=0.
- pc=0, opcode=0110011 → estado sequence 0,1,2,7,0; reg_write=1 only in state 7; pc_inc single pulse; instr_count=1.
- Load (0000011) then store (0100011) → load: 0,1,4,5,8 with mem_read in 5, wb_sel_mem+reg_write in 8. Store: 0,1,4,6 with mem_write in 6. instr_count=2.
- Branch funct3=000: zero=1 → pc_branch=1, pc_inc=0. Repeat with zero=0 → pc_inc=1. With funct3=001 the results invert.
- pc=4 with PROG_LEN=4 in FETCH → HALT next cycle, halted=1 and stays for 10 cycles; reset → FETCH.
- opcode=1111111 → with CTRL_ILLEGAL_TRAP_EN: HALT, illegal=1, instr_count unchanged. Without it: pc_inc in DECODE, back to FETCH, instr_count += 1.
